// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: 3-to-8 decoder fed by a small FIFO. Codes are accepted
// over a valid/ready handshake, then expanded to a one-hot byte. Each byte is
// held on the output for HOLD enabled cycles. The output is gated by en.
module onehot_decoder_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in,
  output logic [7:0]               out,
  output logic                     out_valid,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  // FIFO storage and bookkeeping
  logic [2:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            push, pop;
  logic [2:0]      head;
  logic            fifo_empty;

  // FSM state and its registered outputs
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      out_q, out_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  // in_ready looks only at occupancy, so a full FIFO refuses a push even
  // in a cycle where the FSM pops.
  assign in_ready   = (count_q != CNTW'(DEPTH));
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; count and pointers define which
    // entries are meaningful, so stale contents are never observed.
    if (push) mem_q[wr_ptr_q] <= in;
  end

  // FSM state register plus registered one-hot, valid, counter and done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // FSM next-state: pop and load a code, count down the hold, or retire to IDLE
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en && !fifo_empty) begin
          pop     = 1'b1;
          out_d   = 8'h01 << head;
          valid_d = 1'b1;
          cnt_d   = CW'(HOLD - 1);
          state_d = S_HOLD;
        end else begin
          out_d   = 8'h00;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        // With en low, everything stays frozen via the defaults.
        if (en) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (!fifo_empty) begin
            // Back-to-back: next code replaces the current one with no gap.
            pop     = 1'b1;
            out_d   = 8'h01 << head;
            valid_d = 1'b1;
            cnt_d   = CW'(HOLD - 1);
          end else begin
            out_d   = 8'h00;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: combinational gating by en of the registered one-hot and valid
  always_comb begin
    out       = out_q & {8{en}};
    out_valid = valid_q & en;
    done      = done_q;
    count     = count_q;
  end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Testbench for onehot_decoder_seq. Stimulus pushes expected one-hot bytes
// into a scoreboard queue; a monitor pops one entry per valid output cycle.
module tb_onehot_decoder_seq;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int CW    = 8;

  // Hand-written one-hot value for each 3-bit code
  localparam logic [7:0] ONEHOT [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                        8'h10, 8'h20, 8'h40, 8'h80};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic [7:0] out;
  logic       out_valid;
  logic       done;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;
  logic [7:0] sb [$];

  onehot_decoder_seq #(.DEPTH(DEPTH), .HOLD(HOLD), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_code),
    .out       (out),
    .out_valid (out_valid),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Offer one code; wait (bounded) until accepted. Returns 1ns after the accepting edge.
  task automatic push_code(input logic [2:0] code, input bit expect_out);
    bit acc;
    int waited;
    if (expect_out) repeat (HOLD) sb.push_back(ONEHOT[code]);
    in_valid = 1'b1;
    in_code  = code;
    acc      = 1'b0;
    waited   = 0;
    while (!acc && waited <= 50) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a done pulse and confirm it lasts a single cycle.
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid output cycle consumes one scoreboard entry;
  // an invalid cycle must show a zero output.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_output", {24'd0, out}, 32'd0);
          end else begin
            check("sb_out", {24'd0, out}, {24'd0, sb.pop_front()});
          end
        end else begin
          check("idle_out_zero", {24'd0, out}, 32'd0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with a code offered; nothing must be retained.
    rst      = 1'b1;
    en       = 1'b0;
    in_valid = 1'b1;
    in_code  = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",       {24'd0, out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count",     {29'd0, count}, 32'd0);
    check("rst_done",      {31'd0, done}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_count",    {29'd0, count}, 32'd0);
    mon_on = 1'b1;

    // Single code 5: valid one edge after the push, held 3 cycles, then done.
    en = 1'b1;
    push_code(3'd5, 1'b1);
    check("single_not_yet_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("single_out",       {24'd0, out}, 32'h20);
    check("single_out_valid", {31'd0, out_valid}, 32'd1);
    wait_done(20);
    check("single_sb_empty", sb.size(), 32'd0);
    check("single_count",    {29'd0, count}, 32'd0);

    // Stream codes 0..7 back-to-back; the FIFO fills and in_ready toggles.
    for (int c = 0; c < 8; c++) push_code(3'(c), 1'b1);
    wait_done(100);
    check("stream_sb_empty", sb.size(), 32'd0);
    check("stream_count",    {29'd0, count}, 32'd0);

    // Fill the FIFO while paused; a fifth code is refused.
    en = 1'b0;
    push_code(3'd1, 1'b1);
    push_code(3'd2, 1'b1);
    push_code(3'd3, 1'b1);
    push_code(3'd4, 1'b1);
    check("full_count",    {29'd0, count}, 32'd4);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_code  = 3'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("full_refused_count", {29'd0, count}, 32'd4);
    en = 1'b1;
    wait_done(60);
    check("full_sb_empty", sb.size(), 32'd0);
    check("full_drained",  {29'd0, count}, 32'd0);

    // Pause mid-hold: one en-high cycle of 08, 5 paused cycles, 2 more, then done.
    push_code(3'd3, 1'b1);
    @(posedge clk);
    #1;
    check("pause_first", {24'd0, out}, 32'h08);
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("pause_out",       {24'd0, out}, 32'd0);
      check("pause_out_valid", {31'd0, out_valid}, 32'd0);
    end
    en = 1'b1;
    #1;
    check("resume_out", {24'd0, out}, 32'h08);
    wait_done(20);
    check("pause_sb_empty", sb.size(), 32'd0);

    // Reset mid-operation: 10 held for its full hold, 3 codes queued.
    push_code(3'd4, 1'b1);
    push_code(3'd5, 1'b0);
    push_code(3'd6, 1'b0);
    push_code(3'd7, 1'b0);
    check("midrst_count_before", {29'd0, count}, 32'd3);
    check("midrst_out_before",   {24'd0, out}, 32'h10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out",       {24'd0, out}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_count",     {29'd0, count}, 32'd0);
    check("midrst_done",      {31'd0, done}, 32'd0);
    check("midrst_sb_empty",  sb.size(), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_no_done", {31'd0, done}, 32'd0);

    // Codes pushed after the reset decode normally.
    push_code(3'd2, 1'b1);
    push_code(3'd6, 1'b1);
    wait_done(40);
    check("after_rst_sb_empty", sb.size(), 32'd0);
    check("after_rst_count",    {29'd0, count}, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
Sequenced 3-to-8 decoder that reverses the team's 8-to-3 encoder path. 3-bit codes arrive over a valid/ready handshake and are buffered in a small FIFO. Each code is expanded to a one-hot byte and held on the output for a programmable number of cycles. Typical use is driving one-hot select/strobe lines from a stream of encoded indices.

Parameters:
DEPTH, 4, FIFO entries; power of 2, ≥2.
HOLD, 3, cycles each one-hot value is held; ≥1.
CW, 8, width of the internal hold counter; must satisfy HOLD ≤ 2^CW-1.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  enable; 0 = pause (output gated, hold counter frozen).
in_valid  input  1  code present on in.
in_ready  output  1  FIFO can accept; equals !full.
in  input  3  code to decode.
out  output  8  one-hot decode result, gated by en.
out_valid  output  1  out carries a decoded value (registered flag & en).
done  output  1  one-cycle pulse when the block returns to IDLE.
count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: synchronous and active-high; all state cleared on any clk edge with rst=1, including mid-operation.
  - FIFO flushed (count=0), state=IDLE, out_reg=8'h00, out_valid=0, done=0, counter=0.
  - in_ready=1 in the cycle after reset is released.
- Push: on an edge where in_valid & in_ready, in is written at the tail. Push is accepted regardless of en.
- in_ready = (count != DEPTH). It is not pop-aware, so a full FIFO refuses a push even in a pop cycle.
- Pop: the FSM pops the head. Simultaneous push and pop leaves count unchanged and stores data in order.
- out = out_reg & {8{en}}; out_valid = valid_reg & en. Gating is combinational.
- FSM:
  - IDLE: if en & count≠0 → pop head, out_reg <= 8'h01 << code, valid_reg <= 1, counter <= HOLD-1, go HOLD. Otherwise stay; out_reg=0.
  - HOLD, en=0: counter and out_reg frozen; out reads 0.
  - HOLD, en=1 & counter≠0: counter decrements.
  - HOLD, en=1 & counter=0 & count≠0: pop next, load new one-hot, counter <= HOLD-1, stay HOLD. This gives back-to-back output with no gap.
  - HOLD, en=1 & counter=0 & count=0: out_reg <= 0, valid_reg <= 0, done <= 1 for one cycle, go IDLE.
- Latency: code pushed at edge k into an empty FIFO with the FSM in IDLE and en=1 → out valid after edge k+1. It is held exactly HOLD en-high cycles.
- HOLD=1: counter loads 0; each code is shown for 1 cycle, with streaming back-to-back.
- Ordering: strict FIFO; codes are never dropped or duplicated.
- Pointers wrap modulo DEPTH; count saturates naturally at DEPTH because of in_ready.
- done pulses only on the HOLD→IDLE transition, never on reset.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in=3'd7 → out=8'h00, out_valid=0, count=0, done=0. in_ready=1 after release; no push is retained.
- Single code: en=1, push in=3'd5 (HOLD=3) → out=8'h20, out_valid=1 for exactly 3 cycles starting one edge after the push. Then out=8'h00, with done=1 for one cycle.
- Stream: push codes 0..7 back-to-back with in_valid held high → out sequence 01,02,04,08,10,20,40,80, each for 3 cycles, no zero gap, in_ready toggles as the FIFO fills. The one-hot values mirror the encoder input patterns.
- Full FIFO: en=0, push 3'd1,3'd2,3'd3,3'd4 → count=4, in_ready=0; a fifth in_valid with 3'd6 is not accepted. Raising en → out shows 02,04,08,10 only, and count returns to 0.
- Pause mid-hold: push 3'd3, drop en after 1 cycle of out=8'h08 for 5 cycles → out=8'h00, out_valid=0 during the pause. After en returns, out=8'h08 for the remaining 2 cycles, then done.
- Reset mid-operation: 3 codes queued and out=8'h10 held; assert rst one cycle → next cycle out=8'h00, count=0, state IDLE, no done pulse. Codes pushed afterwards decode normally.
